multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS-subset processor. It sequences instruction fetch, decode, execute, memory and writeback over several cycles, and drives all datapath selects and enables. It generates the 2-bit alu_op consumed by the existing ALU control decoder. It stalls on a memory ready handshake and aborts on a memory wait timeout or an unsupported opcode.

Parameters:
WAIT_LIMIT, 15, maximum consecutive cycles waiting on mem_ready in one memory state before abort (1..255)
CNT_W, 8, width of wait counter; must satisfy 2^CNT_W > WAIT_LIMIT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instr[31:26] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current read/write this cycle
pc_en  out  1  PC load enable = pc_write | (pc_write_cond & zero)
pc_write_cond  out  1  branch-conditional PC write (BRANCH state)
i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR
reg_dst  out  1  destination: 0 = rt, 1 = rd
reg_write  out  1  register file write enable
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
alu_op  out  2  00 = add, 01 = sub, 10 = decode funct
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  out  1  one-cycle pulse: unsupported opcode seen in DECODE
mem_timeout  out  1  one-cycle pulse: wait counter reached WAIT_LIMIT
state  out  4  current state code, for debug

Behaviour:
- Moore FSM. All outputs except pc_en, illegal_op and mem_timeout are decoded from registered state only. Unlisted outputs are 0 in each state.
- Reset: state = FETCH (0); wait counter = 0; illegal_op = mem_timeout = 0.
- Reset outputs are the FETCH decode with mem_ready = 0: mem_read = 1, alu_src_b = 01, all enables 0.
- FETCH (0):
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write = pc_write = mem_ready, combinationally gated.
  - mem_ready = 1 -> DECODE; otherwise stay.
- DECODE (1): alu_src_a = 0, alu_src_b = 11, alu_op = 00. Next state by opcode:
  - 000000 -> EXEC_R
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> EXEC_I
  - any other -> FETCH, with illegal_op = 1 next cycle
- MEM_ADDR (2): alu_src_a = 1, alu_src_b = 10, alu_op = 00. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD (3): mem_read = 1, i_or_d = 1. mem_ready -> WB_LW.
- WB_LW (4): reg_write = 1, mem_to_reg = 1, reg_dst = 0 -> FETCH.
- MEM_WR (5): mem_write = 1, i_or_d = 1, held until mem_ready -> FETCH.
- EXEC_R (6): alu_src_a = 1, alu_src_b = 00, alu_op = 10 -> WB_R.
- WB_R (7): reg_write = 1, reg_dst = 1, mem_to_reg = 0 -> FETCH.
- BRANCH (8): alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01 -> FETCH.
- JUMP (9): pc_write = 1, pc_source = 10 -> FETCH.
- EXEC_I (10): alu_src_a = 1, alu_src_b = 10, alu_op = 00 -> WB_I.
- WB_I (11): reg_write = 1, reg_dst = 0, mem_to_reg = 0 -> FETCH.
- Codes 12..15 are unreachable; if entered, go to FETCH next cycle.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD or MEM_WR, and whenever mem_ready = 1.
  - Increments each cycle in those states while mem_ready = 0.
  - On reaching WAIT_LIMIT with mem_ready still 0: next state = FETCH, mem_timeout pulses 1 cycle, no ir_write/pc_write/reg_write/mem_write effect beyond the request already issued.
  - If mem_ready = 1 in the same cycle as the limit is reached, mem_ready wins: normal advance, no timeout.
- Timeout in FETCH re-fetches from the same PC, since pc_write was never asserted.
- Reset asserted mid-instruction returns to FETCH immediately (async). Any partial store is aborted by mem_write dropping.
- Latency with mem_ready tied 1 (FETCH to FETCH): R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles.

Decomposition:
- Package ctrl_pkg:
  - state encodings S_FETCH..S_WB_I (4-bit)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - alu_op encodings ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - alu_src_b and pc_source select constants
- Sub-module mem_wait_timer (clk, rst_n, clear, count_en, expired) holds the counter.

Test Plan:
- Reset: rst_n low mid-EXEC_R -> state = 0, mem_read = 1, reg_write = 0, illegal_op = 0 on the same cycle.
- R-type, mem_ready = 1: states 0,1,6,7,0; alu_op = 10 in state 6; reg_write = 1, reg_dst = 1 in state 7 only.
- lw with mem_ready low 3 cycles in MEM_RD: state 3 held 4 cycles, mem_read = 1, i_or_d = 1 throughout; WB_LW has mem_to_reg = 1.
- beq: zero = 1 -> pc_en = 1 in state 8; repeat with zero = 0 -> pc_en = 0; alu_op = 01 both runs.
- Opcode 111111 -> DECODE then FETCH; illegal_op high exactly one cycle; no reg_write or mem_write asserted.
- sw with mem_ready held 0, WAIT_LIMIT = 15: after 15 cycles in state 5 -> FETCH, mem_timeout one-cycle pulse. Second run with mem_ready = 1 on the limit cycle -> normal exit, no pulse.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control FSM:
// state codes, opcodes and datapath select values.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_WB_LW    = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_WB_R     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_EXEC_I   = 4'd10,
      S_WB_I     = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that issue a memory request and wait on mem_ready.
   function automatic logic is_wait_state(input state_e s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on memory; flags expiry on the
// cycle the count would reach WAIT_LIMIT.
module mem_wait_timer #(
   parameter int WAIT_LIMIT = 15,
   parameter int CNT_W      = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (count_en)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired = count_en && (cnt_q == CNT_W'(WAIT_LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS-subset core: sequences
// fetch/decode/execute/memory/writeback and drives all datapath controls.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = 15,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic       mem_timeout,
   output logic [3:0] state
);

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;
   logic   timeout_q;
   logic   pc_write;
   logic   wait_clear, wait_count, wait_expired;

   // Counter restarts on every state change, on completion and after a timeout.
   assign wait_count = is_wait_state(state_q) && !mem_ready;
   assign wait_clear = mem_ready || wait_expired || (state_d != state_q);

   mem_wait_timer #(
      .WAIT_LIMIT (WAIT_LIMIT),
      .CNT_W      (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (wait_clear),
      .count_en (wait_count),
      .expired  (wait_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         timeout_q <= wait_expired;
      end
   end

   always_comb begin
      state_d   = state_q;
      illegal_d = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (mem_ready)
               state_d = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     state_d = S_EXEC_R;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_EXEC_I;
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: begin
            if (opcode == OP_LW)
               state_d = S_MEM_RD;
            else if (opcode == OP_SW)
               state_d = S_MEM_WR;
            else
               state_d = S_FETCH;
         end
         S_MEM_RD: begin
            if (mem_ready)
               state_d = S_WB_LW;
            else if (wait_expired)
               state_d = S_FETCH;
         end
         S_MEM_WR: begin
            if (mem_ready || wait_expired)
               state_d = S_FETCH;
         end
         S_EXEC_R: state_d = S_WB_R;
         S_EXEC_I: state_d = S_WB_I;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALUOP_ADD;
      pc_source     = PCSRC_ALU;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: alu_src_b = SRCB_IMM_SH;
         S_MEM_ADDR, S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_WB_LW: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         S_WB_R: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         S_WB_I: reg_write = 1'b1;
         default: ;
      endcase
   end

   assign pc_en       = pc_write | (pc_write_cond & zero);
   assign illegal_op  = illegal_q;
   assign mem_timeout = timeout_q;
   assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each driven cycle queues its expected
// state/outputs, and a negedge monitor compares them against the DUT.
module tb_multicycle_ctrl;

   localparam int WL = 15;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic       illegal_op, mem_timeout;
   logic [3:0] state;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      string       tag;
      logic [3:0]  st;
      logic [15:0] outs;
      logic        ill;
      logic        tmo;
   } exp_t;

   exp_t sb[$];
   logic pend_ill = 1'b0;
   logic pend_tmo = 1'b0;

   multicycle_ctrl #(.WAIT_LIMIT(WL), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
      .state(state)
   );

   always #5 clk = ~clk;

   // Packed view: {pc_en,pwc,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,src_a,src_b,alu_op,pc_source}
   function automatic logic [15:0] exp_outs(input logic [3:0] st, input logic rdy, input logic z);
      logic pe, pwc, iod, mr, mw, irw, m2r, rd, rw, sa;
      logic [1:0] sb_, ao, ps;
      {pe, pwc, iod, mr, mw, irw, m2r, rd, rw, sa} = '0;
      sb_ = 2'b00; ao = 2'b00; ps = 2'b00;
      case (st)
         4'd0:  begin mr = 1; sb_ = 2'b01; irw = rdy; pe = rdy; end
         4'd1:  sb_ = 2'b11;
         4'd2:  begin sa = 1; sb_ = 2'b10; end
         4'd3:  begin mr = 1; iod = 1; end
         4'd4:  begin rw = 1; m2r = 1; end
         4'd5:  begin mw = 1; iod = 1; end
         4'd6:  begin sa = 1; ao = 2'b10; end
         4'd7:  begin rw = 1; rd = 1; end
         4'd8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; pe = z; end
         4'd9:  begin pe = 1; ps = 2'b10; end
         4'd10: begin sa = 1; sb_ = 2'b10; end
         4'd11: rw = 1;
         default: ;
      endcase
      return {pe, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb_, ao, ps};
   endfunction

   function automatic logic [15:0] dut_outs();
      return {pc_en, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
              reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue what the DUT should show in that cycle.
   task automatic cyc(input string tag, input logic [5:0] op, input logic z,
                      input logic rdy, input logic [3:0] st);
      exp_t e;
      opcode = op; zero = z; mem_ready = rdy;
      e.tag = tag; e.st = st; e.outs = exp_outs(st, rdy, z);
      e.ill = pend_ill; e.tmo = pend_tmo;
      pend_ill = 1'b0; pend_tmo = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         check({e.tag, "/state"}, 32'(state), 32'(e.st));
         check({e.tag, "/outs"}, 32'(dut_outs()), 32'(e.outs));
         check({e.tag, "/illegal_op"}, 32'(illegal_op), 32'(e.ill));
         check({e.tag, "/mem_timeout"}, 32'(mem_timeout), 32'(e.tmo));
      end
   end

   initial begin
      rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset/state", 32'(state), 32'd0);
      check("reset/outs", 32'(dut_outs()), 32'(exp_outs(4'd0, 1'b0, 1'b0)));
      check("reset/illegal_op", 32'(illegal_op), 32'd0);
      check("reset/mem_timeout", 32'(mem_timeout), 32'd0);
      rst_n = 1'b1;

      // R-type, memory always ready
      cyc("rtype", 6'b000000, 0, 1, 4'd0);
      cyc("rtype", 6'b000000, 0, 1, 4'd1);
      cyc("rtype", 6'b000000, 0, 1, 4'd6);
      cyc("rtype", 6'b000000, 0, 1, 4'd7);

      // lw with three stall cycles in MEM_RD
      cyc("lw", 6'b100011, 0, 1, 4'd0);
      cyc("lw", 6'b100011, 0, 1, 4'd1);
      cyc("lw", 6'b100011, 0, 1, 4'd2);
      for (int i = 0; i < 3; i++) cyc("lw_stall", 6'b100011, 0, 0, 4'd3);
      cyc("lw", 6'b100011, 0, 1, 4'd3);
      cyc("lw", 6'b100011, 0, 1, 4'd4);

      // beq taken then not taken
      for (int k = 0; k < 2; k++) begin
         logic z;
         z = (k == 0);
         cyc("beq", 6'b000100, z, 1, 4'd0);
         cyc("beq", 6'b000100, z, 1, 4'd1);
         cyc("beq", 6'b000100, z, 1, 4'd8);
      end

      // j and addi
      cyc("j", 6'b000010, 0, 1, 4'd0);
      cyc("j", 6'b000010, 0, 1, 4'd1);
      cyc("j", 6'b000010, 0, 1, 4'd9);
      cyc("addi", 6'b001000, 0, 1, 4'd0);
      cyc("addi", 6'b001000, 0, 1, 4'd1);
      cyc("addi", 6'b001000, 0, 1, 4'd10);
      cyc("addi", 6'b001000, 0, 1, 4'd11);

      // sw with one stall
      cyc("sw", 6'b101011, 0, 1, 4'd0);
      cyc("sw", 6'b101011, 0, 1, 4'd1);
      cyc("sw", 6'b101011, 0, 1, 4'd2);
      cyc("sw_stall", 6'b101011, 0, 0, 4'd5);
      cyc("sw", 6'b101011, 0, 1, 4'd5);

      // unsupported opcode
      cyc("illegal", 6'b111111, 0, 1, 4'd0);
      cyc("illegal", 6'b111111, 0, 1, 4'd1);
      pend_ill = 1'b1;

      // sw timeout: memory never ready
      cyc("sw_to", 6'b101011, 0, 1, 4'd0);
      cyc("sw_to", 6'b101011, 0, 1, 4'd1);
      cyc("sw_to", 6'b101011, 0, 1, 4'd2);
      for (int i = 0; i < WL; i++) cyc("sw_to_wait", 6'b101011, 0, 0, 4'd5);
      pend_tmo = 1'b1;

      // sw with ready arriving exactly on the limit cycle
      cyc("sw_lim", 6'b101011, 0, 1, 4'd0);
      cyc("sw_lim", 6'b101011, 0, 1, 4'd1);
      cyc("sw_lim", 6'b101011, 0, 1, 4'd2);
      for (int i = 0; i < WL - 1; i++) cyc("sw_lim_wait", 6'b101011, 0, 0, 4'd5);
      cyc("sw_lim_last", 6'b101011, 0, 1, 4'd5);

      // fetch timeout re-fetches
      for (int i = 0; i < WL; i++) cyc("fetch_to_wait", 6'b000000, 0, 0, 4'd0);
      pend_tmo = 1'b1;
      cyc("fetch_to", 6'b000000, 0, 0, 4'd0);
      cyc("fetch_to", 6'b000000, 0, 1, 4'd0);
      cyc("rst_mid", 6'b000000, 0, 1, 4'd1);

      // asynchronous reset while in EXEC_R
      @(negedge clk); #1;
      check("rst_mid/pre_state", 32'(state), 32'd6);
      rst_n = 1'b0;
      #1;
      check("rst_mid/state", 32'(state), 32'd0);
      check("rst_mid/mem_read", 32'(mem_read), 32'd1);
      check("rst_mid/reg_write", 32'(reg_write), 32'd0);
      check("rst_mid/illegal_op", 32'(illegal_op), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc("post_rst", 6'b000000, 0, 1, 4'd0);
      cyc("post_rst", 6'b000000, 0, 1, 4'd1);

      @(negedge clk); #1;
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
